// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one read/write request,
// waits WAIT_CYCLES states, then pulses Ready with read data or an error.
// Ports: CLK, Reset (async, active-high), Req (request level),
//        DAddr/DataIn/nRD/nWR (sampled at acceptance),
//        Ready (one-cycle strobe), Dataout (read data), AddrErr (error).
module data_mem_responder #(
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    input  logic        nRD,
    input  logic        nWR,
    output logic        Ready,
    output logic [31:0] Dataout,
    output logic        AddrErr
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        nrd_q;
    logic        nwr_q;

    logic        ready_d;
    logic [31:0] dout_d;
    logic        err_d;
    logic        mem_we;

    logic [7:0]  mem [2**ADDR_W];

    logic        is_wr;
    logic        is_rd;
    logic        bad_addr;
    logic        do_op;
    logic [ADDR_W-1:0] idx0;
    logic [ADDR_W-1:0] idx1;
    logic [ADDR_W-1:0] idx2;
    logic [ADDR_W-1:0] idx3;
    logic [31:0] rdata;

    // Write wins when both selects are low.
    assign is_wr    = ~nwr_q;
    assign is_rd    = nwr_q & ~nrd_q;
    assign bad_addr = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W] != '0);
    assign do_op    = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // Word is aligned when it is used, so the four byte lanes never wrap.
    assign idx0  = {addr_q[ADDR_W-1:2], 2'd0};
    assign idx1  = {addr_q[ADDR_W-1:2], 2'd1};
    assign idx2  = {addr_q[ADDR_W-1:2], 2'd2};
    assign idx3  = {addr_q[ADDR_W-1:2], 2'd3};
    assign rdata = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};

    // State, request latches and registered outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            Ready   <= 1'b0;
            Dataout <= 32'd0;
            AddrErr <= 1'b0;
        end else begin
            state_q <= state_d;
            Ready   <= ready_d;
            Dataout <= dout_d;
            AddrErr <= err_d;
            if (state_q == S_IDLE && Req) begin
                addr_q <= DAddr;
                data_q <= DataIn;
                nrd_q  <= nRD;
                nwr_q  <= nWR;
                cnt_q  <= WAIT_INIT;
            end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Req) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the RAM write strobe,
    // all produced on the edge that enters RESP.
    always_comb begin
        ready_d = 1'b0;
        dout_d  = 32'd0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        if (do_op) begin
            ready_d = 1'b1;
            if (is_wr || is_rd) begin
                if (bad_addr) begin
                    err_d = 1'b1;
                end else if (is_wr) begin
                    mem_we = 1'b1;
                end else begin
                    dout_d = rdata;
                end
            end
        end
    end

    // Big-endian byte RAM; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx0] <= data_q[31:24];
            mem[idx1] <= data_q[23:16];
            mem[idx2] <= data_q[15:8];
            mem[idx3] <= data_q[7:0];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: transaction-level model
// plus per-cycle output comparison and literal directed checks.
module tb_data_mem_responder;

    localparam int W = 2;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic [31:0] DAddr = 32'd0;
    logic [31:0] DataIn = 32'd0;
    logic        nRD = 1'b1;
    logic        nWR = 1'b1;
    logic        Ready;
    logic [31:0] Dataout;
    logic        AddrErr;

    data_mem_responder #(.ADDR_W(7), .WAIT_CYCLES(W)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .Req(Req),
        .DAddr(DAddr),
        .DataIn(DataIn),
        .nRD(nRD),
        .nWR(nWR),
        .Ready(Ready),
        .Dataout(Dataout),
        .AddrErr(AddrErr)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
        logic        rd_n;
        logic        wr_n;
    } txn_t;

    txn_t q[$];
    logic [7:0] mmem [0:127];

    // Response rules at transaction level: {Ready, AddrErr, Dataout}.
    function automatic logic [33:0] respond(txn_t t);
        logic wr;
        logic rd;
        logic bad;
        int   b;
        wr  = !t.wr_n;
        rd  = t.wr_n && !t.rd_n;
        bad = (t.a % 4 != 0) || (t.a >= 128);
        if (!wr && !rd) return {2'b10, 32'd0};
        if (bad) return {2'b11, 32'd0};
        b = int'(t.a);
        if (wr) begin
            for (int i = 0; i < 4; i++) mmem[b + i] = t.d[31 - 8*i -: 8];
            return {2'b10, 32'd0};
        end
        return {2'b10, mmem[b], mmem[b + 1], mmem[b + 2], mmem[b + 3]};
    endfunction

    // Every cycle: outputs must be idle zeros unless a response is due now.
    always @(negedge CLK) begin
        logic [33:0] exp;
        logic [33:0] act;
        act = {Ready, AddrErr, Dataout};
        if (Reset) begin
            q.delete();
            exp = '0;
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            exp = respond(q.pop_front());
        end else begin
            exp = '0;
        end
        check("cycle_outputs", act === exp, 64'(act), 64'(exp));
    end

    task automatic txn(input logic [31:0] a, input logic [31:0] d,
                       input logic rd_n, input logic wr_n,
                       output logic [31:0] dout, output logic err,
                       output int lat);
        int   acc;
        bit   seen;
        txn_t t;
        @(negedge CLK);
        Req = 1'b1;
        DAddr = a;
        DataIn = d;
        nRD = rd_n;
        nWR = wr_n;
        @(posedge CLK);
        #1;
        acc = cyc;
        t.cyc = acc + W + 1;
        t.a = a;
        t.d = d;
        t.rd_n = rd_n;
        t.wr_n = wr_n;
        q.push_back(t);
        @(negedge CLK);
        DAddr = ~a;
        DataIn = ~d;
        nRD = ~rd_n;
        nWR = ~wr_n;
        seen = 0;
        dout = '0;
        err = 1'b0;
        lat = -1;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (Ready) begin
                seen = 1;
                lat = cyc - acc;
                dout = Dataout;
                err = AddrErr;
            end else begin
                @(negedge CLK);
            end
        end
        if (!seen) check("ready_timeout", 1'b0, 64'd0, 64'd1);
        Req = 1'b0;
        @(negedge CLK);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          a1;
    int          pulses;
    int          r1c;
    int          r2c;
    logic [31:0] r1d;
    logic [31:0] r2d;
    txn_t        t2;

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_ready", Ready === 1'b0, 64'(Ready), 64'd0);
        check("reset_dout", Dataout === 32'd0, 64'(Dataout), 64'd0);
        check("reset_err", AddrErr === 1'b0, 64'(AddrErr), 64'd0);
        Reset = 1'b0;
        @(negedge CLK);

        txn(32'h00, 32'h01020304, 1'b1, 1'b0, rd, er, lat);
        txn(32'h04, 32'h05060708, 1'b1, 1'b0, rd, er, lat);
        txn(32'h14, 32'h22222222, 1'b1, 1'b0, rd, er, lat);

        txn(32'h08, 32'h12345678, 1'b1, 1'b0, rd, er, lat);
        check("wr08_dout", rd === 32'd0, 64'(rd), 64'd0);
        txn(32'h08, 32'h0, 1'b0, 1'b1, rd, er, lat);
        check("rd08_data", rd === 32'h12345678, 64'(rd), 64'h12345678);
        check("rd08_err", er === 1'b0, 64'(er), 64'd0);

        txn(32'h0C, 32'hAABBCCDD, 1'b1, 1'b0, rd, er, lat);
        txn(32'h0C, 32'h0, 1'b0, 1'b1, rd, er, lat);
        check("rd0c_data", rd === 32'hAABBCCDD, 64'(rd), 64'hAABBCCDD);
        check("rd0c_latency", lat == 3, 64'(lat), 64'd3);
        check("idle_after_resp", Ready === 1'b0, 64'(Ready), 64'd0);

        txn(32'h06, 32'h0, 1'b0, 1'b1, rd, er, lat);
        check("rd06_err", er === 1'b1, 64'(er), 64'd1);
        check("rd06_dout", rd === 32'd0, 64'(rd), 64'd0);
        txn(32'h80, 32'hFFFFFFFF, 1'b1, 1'b0, rd, er, lat);
        check("wr80_err", er === 1'b1, 64'(er), 64'd1);
        txn(32'h00, 32'h0, 1'b0, 1'b1, rd, er, lat);
        check("rd00_unchanged", rd === 32'h01020304, 64'(rd), 64'h01020304);

        txn(32'h10, 32'hCAFEF00D, 1'b0, 1'b0, rd, er, lat);
        check("both_low_dout", rd === 32'd0, 64'(rd), 64'd0);
        txn(32'h10, 32'h0, 1'b0, 1'b1, rd, er, lat);
        check("rd10_data", rd === 32'hCAFEF00D, 64'(rd), 64'hCAFEF00D);
        txn(32'h10, 32'h55555555, 1'b1, 1'b1, rd, er, lat);
        check("noop_dout", rd === 32'd0, 64'(rd), 64'd0);
        check("noop_err", er === 1'b0, 64'(er), 64'd0);
        check("noop_latency", lat == 3, 64'(lat), 64'd3);
        txn(32'h10, 32'h0, 1'b0, 1'b1, rd, er, lat);
        check("rd10_after_noop", rd === 32'hCAFEF00D, 64'(rd), 64'hCAFEF00D);

        // Reset while a write sits in WAIT: the write must be lost.
        @(negedge CLK);
        Req = 1'b1;
        DAddr = 32'h14;
        DataIn = 32'h11111111;
        nRD = 1'b1;
        nWR = 1'b0;
        @(posedge CLK);
        #1;
        t2.cyc = cyc + W + 1;
        t2.a = 32'h14;
        t2.d = 32'h11111111;
        t2.rd_n = 1'b1;
        t2.wr_n = 1'b0;
        q.push_back(t2);
        @(negedge CLK);
        Req = 1'b0;
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        check("rst_mid_ready", Ready === 1'b0, 64'(Ready), 64'd0);
        check("rst_mid_dout", Dataout === 32'd0, 64'(Dataout), 64'd0);
        check("rst_mid_err", AddrErr === 1'b0, 64'(AddrErr), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        txn(32'h14, 32'h0, 1'b0, 1'b1, rd, er, lat);
        check("rd14_kept", rd === 32'h22222222, 64'(rd), 64'h22222222);

        // Req held across two reads, address churned during WAIT.
        @(negedge CLK);
        Req = 1'b1;
        DAddr = 32'h00;
        DataIn = 32'h0;
        nRD = 1'b0;
        nWR = 1'b1;
        @(posedge CLK);
        #1;
        a1 = cyc;
        t2.cyc = a1 + W + 1;
        t2.a = 32'h00;
        t2.d = 32'h0;
        t2.rd_n = 1'b0;
        t2.wr_n = 1'b1;
        q.push_back(t2);
        pulses = 0;
        r1c = -1;
        r2c = -1;
        r1d = '0;
        r2d = '0;
        for (int n = 0; n <= 10; n++) begin
            @(negedge CLK);
            if (n == 1) DAddr = 32'h04;
            if (n == 4) begin
                t2.cyc = a1 + 2*W + 4;
                t2.a = 32'h04;
                q.push_back(t2);
            end
            if (n == 6) DAddr = 32'h08;
            if (Ready) begin
                pulses++;
                if (pulses == 1) begin
                    r1c = cyc - a1;
                    r1d = Dataout;
                end else begin
                    r2c = cyc - a1;
                    r2d = Dataout;
                end
            end
            if (n == 8) Req = 1'b0;
        end
        check("held_pulses", pulses == 2, 64'(pulses), 64'd2);
        check("held_r1_cycle", r1c == 3, 64'(r1c), 64'd3);
        check("held_r2_cycle", r2c == 8, 64'(r2c), 64'd8);
        check("held_r1_data", r1d === 32'h01020304, 64'(r1d), 64'h01020304);
        check("held_r2_data", r2d === 32'h05060708, 64'(r2d), 64'h05060708);

        repeat (2) @(negedge CLK);
        check("queue_drained", q.size() == 0, 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
